// File: rtl/mux_rr_pkg.sv
// Shared constants and helpers for the registered round-robin channel selector.
package mux_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n items, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_reg_rr_arbiter.sv
// Rotating-priority request search: the first requester after ptr wins.
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int NUM_CH = 32,
  parameter int SEL_W  = 5
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              enable,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_vld
);

  int idx;

  // Walk ptr+1, ptr+2, ... (wrapping) and keep the first active request.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (enable && !grant_vld && req[idx]) begin
        grant     = idx[SEL_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// Registered N-channel selector with valid/ready per channel, fixed or
// round-robin selection, and a single bubble-free output register.
module mux_rr_reg
  import mux_rr_pkg::*;
#(
  parameter  int NUM_CH = 32,
  parameter  int DATA_W = 2,
  localparam int SEL_W  = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     sel_err
);

  logic              load_en;
  logic              sel_in_range;
  logic              sel_req;
  logic [SEL_W-1:0]  rr_grant;
  logic              rr_vld;
  logic [SEL_W-1:0]  grant;
  logic              grant_vld;
  logic              transfer;
  logic [DATA_W-1:0] grant_data;

  logic [DATA_W-1:0] data_p1;
  logic [SEL_W-1:0]  sel_p1;
  logic              vld_p1;
  logic              err_p1;
  logic [SEL_W-1:0]  rr_ptr;

  // A power-of-two channel count makes every sel encoding a real channel.
  if ((1 << SEL_W) == NUM_CH) begin : g_sel_full
    assign sel_in_range = 1'b1;
  end else begin : g_sel_partial
    assign sel_in_range = (sel < SEL_W'(NUM_CH));
  end

  // Valid of the externally selected channel, decoded without out-of-range indexing.
  always_comb begin
    sel_req = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) sel_req = in_valid[i];
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .enable    (mode == MODE_RR),
    .grant     (rr_grant),
    .grant_vld (rr_vld)
  );

  assign grant     = (mode == MODE_RR) ? rr_grant : sel;
  assign grant_vld = (mode == MODE_RR) ? rr_vld : (sel_in_range && sel_req);

  // Output register may load when empty or when its beat leaves this cycle;
  // no handshake is offered while reset is held.
  assign load_en  = !vld_p1 || out_ready;
  assign transfer = rst_n && load_en && grant_vld;

  // One-hot ready to the granted channel only on a transfer.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (transfer && (grant == SEL_W'(i))) in_ready[i] = 1'b1;
    end
  end

  // Data of the granted channel.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_W'(i)) grant_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  // ---- stage p1: output register, RR pointer and sel error flag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      sel_p1  <= '0;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      rr_ptr  <= SEL_W'(NUM_CH - 1);
    end else begin
      if (transfer) begin
        data_p1 <= grant_data;
        sel_p1  <= grant;
        vld_p1  <= 1'b1;
      end else if (out_ready && vld_p1) begin
        vld_p1  <= 1'b0;
      end
      if (transfer && (mode == MODE_RR)) rr_ptr <= grant;
      err_p1 <= (mode == MODE_FIXED) && !sel_in_range;
    end
  end

  assign out_data  = data_p1;
  assign out_sel   = sel_p1;
  assign out_valid = vld_p1;
  assign sel_err   = err_p1;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: directed scenarios plus random traffic against a
// transaction-level model of the selector (32 channels), and a 20-channel
// instance for the out-of-range select behaviour.
module tb_mux_rr_reg;

  localparam int N  = 32;
  localparam int W  = 2;
  localparam int N2 = 20;

  logic          clk = 1'b0;
  logic          rst_n;

  logic          mode;
  logic [4:0]    sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_sel;
  logic          sel_err;

  logic          mode2;
  logic [4:0]    sel2;
  logic [N2*W-1:0] in_data2;
  logic [N2-1:0] in_valid2;
  logic [N2-1:0] in_ready2;
  logic [W-1:0]  out_data2;
  logic          out_valid2;
  logic          out_ready2;
  logic [4:0]    out_sel2;
  logic          sel_err2;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state
  bit m_vld;
  int m_data;
  int m_sel;
  int m_ptr;
  bit m_err;

  int rr_exp[5] = '{0, 5, 31, 0, 5};

  always #5 clk = ~clk;

  mux_rr_reg #(.NUM_CH(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .sel_err(sel_err)
  );

  mux_rr_reg #(.NUM_CH(N2), .DATA_W(W)) dut20 (
    .clk(clk), .rst_n(rst_n), .mode(mode2), .sel(sel2),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sel(out_sel2), .sel_err(sel_err2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = 0;
    m_sel  = 0;
    m_ptr  = N - 1;
    m_err  = 1'b0;
  endtask

  // Which channel the rules say gets served with the current inputs.
  task automatic model_grant(output bit gv, output int g);
    int c;
    gv = 1'b0;
    g  = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) begin
        gv = 1'b1;
        g  = int'(sel);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (!gv && in_valid[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
  endtask

  // One clock cycle on the 32-channel instance with model checking.
  task automatic step();
    bit gv, ld, go, md, ordy;
    int g, s, d;
    logic [63:0] exp_rdy;
    #2;
    model_grant(gv, g);
    ld      = !m_vld || out_ready;
    go      = rst_n && ld && gv;
    exp_rdy = go ? (64'd1 << g) : 64'd0;
    check("in_ready", {32'd0, in_ready}, exp_rdy);
    d    = int'(in_data[g*W +: W]);
    md   = mode;
    s    = int'(sel);
    ordy = out_ready;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (go) begin
        m_vld  = 1'b1;
        m_data = d;
        m_sel  = g;
        if (md) m_ptr = g;
      end else if (ordy && m_vld) begin
        m_vld = 1'b0;
      end
      m_err = !md && (s >= N);
    end
    #1;
    check("out_valid", out_valid, m_vld);
    check("out_data", out_data, m_data);
    check("out_sel", out_sel, m_sel);
    check("sel_err", sel_err, m_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs
    rst_n      = 1'b0;
    mode       = 1'($urandom);
    sel        = 5'($urandom);
    in_data    = {$urandom, $urandom};
    in_valid   = $urandom;
    out_ready  = 1'($urandom);
    mode2      = 1'b0;
    sel2       = 5'd0;
    in_data2   = {8'($urandom), $urandom};
    in_valid2  = 20'($urandom);
    out_ready2 = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_sel_err", sel_err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_in_ready20", in_ready2, 0);
    check("rst_out_valid20", out_valid2, 0);
    rst_n     = 1'b1;
    in_valid2 = '0;

    // Fixed select of channel 30
    mode      = 1'b0;
    sel       = 5'd30;
    in_valid  = 32'h4000_0000;
    in_data   = {$urandom, $urandom};
    in_data[61:60] = 2'b11;
    out_ready = 1'b1;
    #1;
    check("fix_rdy", in_ready, 32'h4000_0000);
    step();
    check("fix_data", out_data, 2'b11);
    check("fix_sel", out_sel, 30);
    check("fix_vld", out_valid, 1);

    // Top channel maps correctly
    sel       = 5'd31;
    in_valid  = 32'hC000_0000;
    in_data[63:62] = 2'b10;
    in_data[61:60] = 2'b01;
    step();
    check("ch31_data", out_data, 2'b10);
    check("ch31_sel", out_sel, 31);

    // Round-robin over ch0, ch5, ch31
    mode     = 1'b1;
    in_valid = 32'h8000_0021;
    for (int i = 0; i < 5; i++) begin
      in_data = {$urandom, $urandom};
      step();
      check("rr_seq", out_sel, rr_exp[i]);
    end

    // Backpressure holding the ch5 beat
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      step();
      check("bp_sel", out_sel, 5);
      check("bp_vld", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_rdy", in_ready, 32'h8000_0000);
    step();
    check("bp_resume_sel", out_sel, 31);

    // 20-channel instance: out-of-range sel
    in_valid  = '0;
    sel2      = 5'd3;
    in_valid2 = '1;
    in_data2  = {8'($urandom), $urandom};
    step();
    check("oor_load_vld", out_valid2, 1);
    check("oor_load_sel", out_sel2, 3);
    check("oor_load_err", sel_err2, 0);
    sel2 = 5'd25;
    #1;
    check("oor_rdy", in_ready2, 0);
    step();
    check("oor_err", sel_err2, 1);
    check("oor_drain", out_valid2, 0);
    sel2 = 5'd3;
    #1;
    check("oor_back_rdy", in_ready2, 20'h00008);
    step();
    check("oor_clear_err", sel_err2, 0);
    check("oor_back_vld", out_valid2, 1);
    in_valid2 = '0;
    sel2      = 5'd0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel       = 5'($urandom);
      in_valid  = $urandom & $urandom;
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset asserted while a beat is held
    mode      = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_sel", out_sel, 0);
    check("mid_rst_rdy", in_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 32'h8000_0021;
    step();
    check("post_rst_rr", out_sel, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
Parametrised, registered N-channel data selector with per-channel valid/ready handshake. Two selection modes: fixed (external sel) and round-robin among valid channels. One output register stage provides full throughput under backpressure. Sits where the combinational channel mux is used today, for datapaths that need flow control and fair sharing.

Parameters:
NUM_CH, 32, number of input channels (2..64).
DATA_W, 2, width of each channel's data.
SEL_W, $clog2(NUM_CH), width of sel and out_sel (derived, not overridden).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
mode  in  1  0 = fixed select, 1 = round-robin.
sel  in  SEL_W  channel index in fixed mode; ignored in RR mode.
in_data  in  NUM_CH*DATA_W  flattened; channel i at [i*DATA_W +: DATA_W].
in_valid  in  NUM_CH  per-channel valid.
in_ready  out  NUM_CH  per-channel ready; at most one bit set.
out_data  out  DATA_W  registered selected data.
out_valid  out  1  out_data holds a beat.
out_ready  in  1  downstream accepts.
out_sel  out  SEL_W  channel index of the beat in out_data.
sel_err  out  1  registered flag: fixed mode with sel >= NUM_CH in the previous cycle.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, sel_err=0, RR pointer=NUM_CH-1, so the first RR search starts at ch0.
- load_en = !out_valid || out_ready. This is the combinational bubble-free pipeline register.
- Grant, fixed mode: grant_vld = (sel < NUM_CH) && in_valid[sel]; grant = sel.
- Grant, RR mode: search channels ptr+1, ptr+2, ... with wrap modulo NUM_CH. Grant the first with in_valid=1; grant_vld=0 if none are valid.
- in_ready[i] = load_en && grant_vld && (grant == i). All other in_ready bits are 0.
- Transfer when load_en && grant_vld. Next edge: out_data <= channel grant, out_sel <= grant, out_valid <= 1.
- No transfer and out_ready && out_valid: out_valid <= 0; out_data and out_sel hold.
- out_valid=1 and out_ready=0: out_data, out_sel and out_valid hold; all in_ready=0.
- Latency: input handshake cycle N gives out_valid in cycle N+1. Sustained throughput is 1 beat/cycle with out_ready held high.
- RR pointer updates to grant only on a transfer in RR mode. It is unchanged in fixed mode and unchanged on stalls.
- Mode or sel change applies combinationally to the current cycle's grant. The beat already in the output register is unaffected.
- sel_err <= (mode==0) && (sel >= NUM_CH) every cycle. No grant is made for an out-of-range sel. When NUM_CH is a power of two, sel_err stays 0.
- in_valid dropping without a handshake is legal. Data is sampled only in the transfer cycle.
- Reset asserted mid-transfer: the register content is discarded and outputs take reset values immediately.

Decomposition:
- Package mux_rr_pkg: MODE_FIXED=1'b0 and MODE_RR=1'b1 constants, plus a clog2 helper function.
- Sub-module rr_arbiter: inputs req[NUM_CH], ptr, enable; outputs grant index and grant_vld. Purely combinational rotate-priority search.
- Top module: fixed/RR grant mux, ready generation, output register, pointer register, sel_err register.

Test Plan:
- Reset: rst_n=0 with random inputs → out_valid=0, out_data=0, out_sel=0, sel_err=0, in_ready=0.
- Fixed select: mode=0, sel=30, in_valid[30]=1, ch30 data=2'b11, out_ready=1 → in_ready[30]=1 only; next cycle out_data=2'b11, out_sel=30, out_valid=1.
- Channel 31: mode=0, sel=31, ch31 data=2'b10, ch30 data=2'b01 → out_data=2'b10, out_sel=31. This proves the top channel maps correctly.
- Round-robin: mode=1, in_valid=ch0|ch5|ch31 held, out_ready=1 → out_sel sequence 0, 5, 31, 0, 5, one beat per cycle.
- Backpressure: beat from ch5 in output register, out_ready=0 for 3 cycles → out_data/out_sel/out_valid stable, in_ready=0, RR pointer unchanged. out_ready=1 → next grant is ch31.
- Out-of-range: NUM_CH=20, mode=0, sel=25 → no in_ready, sel_err=1 the following cycle, out_valid drains to 0. With sel=3 the next cycle, sel_err=0 one cycle later.
